uart_reg_bridge: RTL
====================

// Module: uart_reg_bridge
// PURPOSE
//  Command decoder between the buart byte interface and an 8-bit register bus.
//  Consumes received bytes with a valid/rd strobe handshake and decodes them into
//  register reads and writes. Read results go back to the host through the uart
//  wr/busy handshake. This block replaces the loopback logic in board tops.
// PARAMETERS
//  TIMEOUT_CYCLES  960_000  inter-byte timeout in clk cycles (10 ms @ 96 MHz); only used with UART_BRIDGE_TIMEOUT_EN
//  RD_WAIT_MAX     255      max clk cycles to wait for reg_rd_valid after reg_read
// PORTS
//  clk           in   1  system clock (same clock as buart)
//  reset         in   1  asynchronous, active-high reset
//  rx_valid      in   1  buart has a received byte
//  rx_data       in   8  buart received byte
//  uart_rd       out  1  one-cycle read strobe to buart; pops rx byte
//  tx_busy       in   1  buart transmitting
//  uart_wr       out  1  one-cycle write strobe to buart
//  tx_data       out  8  byte to transmit; stable from uart_wr until next SEND
//  reg_addr      out  7  register address
//  reg_wr_data   out  8  register write data
//  reg_write     out  1  one-cycle register write strobe
//  reg_read      out  1  one-cycle register read strobe
//  reg_rd_data   in   8  register read data, sampled when reg_rd_valid=1
//  reg_rd_valid  in   1  read data valid (may be the same cycle as reg_read+1 or later)
//  err           out  1  sticky: read timeout or inter-byte timeout; cleared by reset only
// BEHAVIOUR
//  - Reset (async, active-high): every output is 0. State is IDLE. All counters are 0.
//  - Protocol: byte0 = {rw, addr[6:0]}; rw=1 write, rw=0 read.
//    Write: byte1 = data. No reply. Read: one reply byte = register data.
//  - Rx handshake: byte accepted when rx_valid=1 in a byte-taking state; then uart_rd=1
//    for exactly one cycle. rx_data is latched in that cycle. rx_valid is ignored the
//    cycle after uart_rd (buart deassert latency), so there is never a double pop.
//  - States:
//    IDLE     rx byte -> latch addr; rw=1 -> GET_DATA, rw=0 -> DO_READ
//    GET_DATA rx byte -> reg_wr_data=byte -> DO_WRITE
//    DO_WRITE reg_write=1 for one cycle -> IDLE
//    DO_READ  reg_read=1 for one cycle -> WAIT_RD
//    WAIT_RD  reg_rd_valid -> latch tx_data=reg_rd_data -> SEND
//             RD_WAIT_MAX cycles without valid -> tx_data=8'hEE, err=1 -> SEND
//    SEND     wait until tx_busy=0, then uart_wr=1 for one cycle -> SEND_GAP
//    SEND_GAP one guard cycle, tx_busy not sampled (buart busy latency) -> IDLE
//  - Latency:
//    Write: reg_write is 2 clk after the cycle byte1 is accepted (accept -> DO_WRITE -> strobe).
//    Read: reg_read is 2 clk after byte0 is accepted. uart_wr is at least 1 clk after reg_rd_valid.
//  - reg_addr and reg_wr_data hold their values until the next command overwrites them.
//  - Strobes are never asserted together. At most one of uart_rd, uart_wr, reg_write, reg_read is high per cycle.
//  - Bytes that arrive during WAIT_RD/SEND/SEND_GAP stay in buart until IDLE. They are not dropped.
//  - Reset mid-command: the partial command is discarded. A strobe in flight is cut off asynchronously.
//  - RD_WAIT_MAX counter saturates; it does not wrap.
// CONFIGURATION
//  UART_BRIDGE_TIMEOUT_EN defined:
//    - In GET_DATA, a 20-bit idle counter increments each cycle with no byte.
//    - When the counter reaches TIMEOUT_CYCLES-1: return to IDLE, set err=1, issue no reg_write.
//    - The counter clears on every accepted byte and on entry to GET_DATA.
//  UART_BRIDGE_TIMEOUT_EN undefined:
//    - GET_DATA waits forever.
//    - err is set only by a read timeout.
//    - No counter logic is synthesised.
// TESTING
//  1 write: rx 8'h85,8'h3C -> reg_write one pulse, addr=7'h05, wr_data=8'h3C; no uart_wr
//  2 read: rx 8'h12; reg_rd_data=8'hA7 with valid 3 clk after reg_read -> one reg_read,
//    addr=7'h12; uart_wr once, tx_data=8'hA7
//  3 back-to-back: rx_valid held high with 8'h81,8'h55,8'h02 queued -> exactly 3 uart_rd
//    pulses, none adjacent; write then read complete in order
//  4 tx stall: tx_busy=1 for 500 clk during SEND -> uart_wr only after busy falls, once
//  5 read timeout: never assert reg_rd_valid -> after RD_WAIT_MAX clk tx_data=8'hEE, err=1
//  6 macro on, TIMEOUT_CYCLES=100: rx 8'h90 then nothing -> IDLE at 100 clk, err=1,
//    no reg_write; next 8'h90,8'h01 writes normally. Reset asserted in GET_DATA -> all outputs 0 at once

Source files
------------

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes buart byte commands into 8-bit register bus accesses.
//   byte0 = {rw, addr[6:0]}; rw=1 write (byte1 = data, no reply), rw=0 read
//   (one reply byte = register data, or 8'hEE on read timeout).
// Optional feature macro: UART_BRIDGE_TIMEOUT_EN enables an inter-byte timeout
//   in GET_DATA (TIMEOUT_CYCLES); without it GET_DATA waits forever.
// Ports:
//   clk, reset (async, active-high)
//   rx_valid/rx_data in, uart_rd out       : buart receive side, pop strobe
//   tx_busy in, uart_wr/tx_data out        : buart transmit side
//   reg_addr/reg_wr_data/reg_write/reg_read out, reg_rd_data/reg_rd_valid in
//   err out                                : sticky timeout flag
module uart_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 960_000,
    parameter int unsigned RD_WAIT_MAX    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       uart_rd,
    input  logic       tx_busy,
    output logic       uart_wr,
    output logic [7:0] tx_data,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_write,
    output logic       reg_read,
    input  logic [7:0] reg_rd_data,
    input  logic       reg_rd_valid,
    output logic       err
);

    localparam int unsigned RD_CNT_W   = $clog2(RD_WAIT_MAX + 1);
    localparam int unsigned IDLE_CNT_W = 20;

    // Parameter sanity checks at elaboration.
    if (RD_WAIT_MAX < 1) begin : g_bad_rd_wait
        $error("RD_WAIT_MAX must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << IDLE_CNT_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..2**20");
    end

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        DO_WRITE,
        DO_READ,
        WAIT_RD,
        SEND,
        SEND_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [6:0]          addr_q, addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                uart_rd_q, uart_rd_d;
    logic                rd_hold_q, rd_hold_d;
    logic                uart_wr_q, uart_wr_d;
    logic                reg_write_q, reg_write_d;
    logic                reg_read_q, reg_read_d;
    logic                err_q, err_d;
    logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    // rx_valid is blind during the pop strobe and the cycle after it, so a
    // byte is never popped twice while buart deasserts valid.
    logic rx_take;
    assign rx_take = rx_valid && !uart_rd_q && !rd_hold_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        tx_data_d   = tx_data_q;
        uart_rd_d   = 1'b0;
        rd_hold_d   = uart_rd_q;
        uart_wr_d   = 1'b0;
        reg_write_d = 1'b0;
        reg_read_d  = 1'b0;
        err_d       = err_q;
        rd_cnt_d    = rd_cnt_q;
`ifdef UART_BRIDGE_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_take) begin
                    addr_d    = rx_data[6:0];
                    uart_rd_d = 1'b1;
                    state_d   = rx_data[7] ? GET_DATA : DO_READ;
`ifdef UART_BRIDGE_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            GET_DATA: begin
                if (rx_take) begin
                    wr_data_d = rx_data;
                    uart_rd_d = 1'b1;
                    state_d   = DO_WRITE;
`ifdef UART_BRIDGE_TIMEOUT_EN
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the half-received write; no reg_write is issued.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
`endif
                end
            end
            DO_WRITE: begin
                reg_write_d = 1'b1;
                state_d     = IDLE;
            end
            DO_READ: begin
                reg_read_d = 1'b1;
                rd_cnt_d   = '0;
                state_d    = WAIT_RD;
            end
            WAIT_RD: begin
                if (reg_rd_valid) begin
                    tx_data_d = reg_rd_data;
                    state_d   = SEND;
                end else if (rd_cnt_q == RD_CNT_W'(RD_WAIT_MAX - 1)) begin
                    tx_data_d = 8'hEE;
                    err_d     = 1'b1;
                    state_d   = SEND;
                end else if (rd_cnt_q != RD_CNT_W'(RD_WAIT_MAX)) begin
                    rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    uart_wr_d = 1'b1;
                    state_d   = SEND_GAP;
                end
            end
            SEND_GAP: begin
                // buart raises busy one cycle after uart_wr; skip sampling it here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
            uart_rd_q   <= 1'b0;
            rd_hold_q   <= 1'b0;
            uart_wr_q   <= 1'b0;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            err_q       <= 1'b0;
            rd_cnt_q    <= '0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            tx_data_q   <= tx_data_d;
            uart_rd_q   <= uart_rd_d;
            rd_hold_q   <= rd_hold_d;
            uart_wr_q   <= uart_wr_d;
            reg_write_q <= reg_write_d;
            reg_read_q  <= reg_read_d;
            err_q       <= err_d;
            rd_cnt_q    <= rd_cnt_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign uart_rd     = uart_rd_q;
    assign uart_wr     = uart_wr_q;
    assign tx_data     = tx_data_q;
    assign reg_addr    = addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_write   = reg_write_q;
    assign reg_read    = reg_read_q;
    assign err         = err_q;

endmodule
